// File: rtl/iq_frame_buffer.sv
// Ping-pong frame buffer: two 2^ADDR_W-word banks between the IQ demodulator
// and the Ethernet frame transmitter, with a saturating drop counter.
module iq_frame_buffer #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 16,
    parameter int OVF_W  = 16
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_empty,
    input  logic              tx_complete,
    output logic [OVF_W-1:0]  overflow_cnt,
    output logic [3:0]        bank_state
);

    typedef enum logic [1:0] {
        FREE    = 2'd0,
        FILLING = 2'd1,
        READY   = 2'd2,
        SENDING = 2'd3
    } bank_st_e;

    bank_st_e            bank_q [2];
    bank_st_e            bank_d [2];
    logic                wr_bank_q, wr_bank_d;
    logic [ADDR_W-1:0]   wr_cnt_q, wr_cnt_d;
    logic                rd_bank_q, rd_bank_d;
    logic                tc_q, tc_d;
    logic [OVF_W-1:0]    ovf_q, ovf_d;
    logic [DATA_W-1:0]   rd_data_q, rd_data_d;

    logic [DATA_W-1:0]   mem_q [2**(ADDR_W+1)];

    logic                wr_busy;
    logic                we;
    logic                tc_fall;
    logic                tc_rise;

    always_comb begin
        bank_d    = bank_q;
        wr_bank_d = wr_bank_q;
        wr_cnt_d  = wr_cnt_q;
        rd_bank_d = rd_bank_q;
        ovf_d     = ovf_q;
        tc_d      = tx_complete;
        we        = 1'b0;
        rd_data_d = mem_q[{rd_bank_q, rd_addr}];
        wr_busy   = (bank_q[wr_bank_q] == READY) ||
                    (bank_q[wr_bank_q] == SENDING);
        tc_fall   = tc_q & ~tx_complete;
        tc_rise   = ~tc_q & tx_complete;

        if (in_valid) begin
            if (!wr_busy) begin
                we       = ~Reset;
                wr_cnt_d = wr_cnt_q + 1'b1;
                if (wr_cnt_q == '1) begin
                    bank_d[wr_bank_q] = READY;
                    wr_bank_d         = ~wr_bank_q;
                end else begin
                    bank_d[wr_bank_q] = FILLING;
                end
            end else if (ovf_q != '1) begin
                ovf_d = ovf_q + 1'b1;
            end
        end

        // The read bank is READY/SENDING, the write bank FREE/FILLING,
        // so these updates never touch the bank changed above.
        if (tc_fall && bank_q[rd_bank_q] == READY) begin
            bank_d[rd_bank_q] = SENDING;
        end
        if (tc_rise && bank_q[rd_bank_q] == SENDING) begin
            bank_d[rd_bank_q] = FREE;
            rd_bank_d         = ~rd_bank_q;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            bank_q[0] <= FREE;
            bank_q[1] <= FREE;
            wr_bank_q <= 1'b0;
            wr_cnt_q  <= '0;
            rd_bank_q <= 1'b0;
            tc_q      <= 1'b1;
            ovf_q     <= '0;
            rd_data_q <= '0;
        end else begin
            bank_q    <= bank_d;
            wr_bank_q <= wr_bank_d;
            wr_cnt_q  <= wr_cnt_d;
            rd_bank_q <= rd_bank_d;
            tc_q      <= tc_d;
            ovf_q     <= ovf_d;
            rd_data_q <= rd_data_d;
        end
    end

    always_ff @(posedge Clk) begin
        if (we) begin
            mem_q[{wr_bank_q, wr_cnt_q}] <= in_data;
        end
    end

    assign rd_data      = rd_data_q;
    assign overflow_cnt = ovf_q;
    assign bank_state   = {bank_q[1], bank_q[0]};
    assign rd_empty     = !((bank_q[rd_bank_q] == READY) ||
                            (bank_q[rd_bank_q] == SENDING));

endmodule

// File: tb/tb_iq_frame_buffer.sv
// Directed bench for iq_frame_buffer: fill, send, overflow, saturation,
// same-cycle release and reset recovery.
module tb_iq_frame_buffer;

    localparam int OVF_W = 8;

    logic             Clk;
    logic             Reset;
    logic             in_valid;
    logic [15:0]      in_data;
    logic [8:0]       rd_addr;
    logic [15:0]      rd_data;
    logic             rd_empty;
    logic             tx_complete;
    logic [OVF_W-1:0] overflow_cnt;
    logic [3:0]       bank_state;

    iq_frame_buffer #(
        .ADDR_W(9),
        .DATA_W(16),
        .OVF_W (OVF_W)
    ) dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data),
        .rd_empty    (rd_empty),
        .tx_complete (tx_complete),
        .overflow_cnt(overflow_cnt),
        .bank_state  (bank_state)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    typedef struct {
        logic [8:0]  addr;
        logic [15:0] exp;
    } rd_vec_t;

    rd_vec_t rv [12];
    int      vecs;
    int      errs;

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic check(input string name,
                         input logic [31:0] act,
                         input logic [31:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic fill(input int n, input logic [15:0] base);
        for (int i = 0; i < n; i++) begin
            in_valid = 1'b1;
            in_data  = base + 16'(i);
            tick();
        end
        in_valid = 1'b0;
    endtask

    task automatic rd_tab(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            rd_addr = rv[i].addr;
            tick();
            check($sformatf("rd_tab[%0d]", i), 32'(rd_data),
                  32'(rv[i].exp));
        end
    endtask

    task automatic rd_one(input string name, input logic [8:0] a,
                          input logic [15:0] e);
        rd_addr = a;
        tick();
        check(name, 32'(rd_data), 32'(e));
    endtask

    task automatic chk_reset(input string tag);
        check({tag, " bank_state"}, 32'(bank_state), 32'h0);
        check({tag, " rd_empty"}, 32'(rd_empty), 32'h1);
        check({tag, " ovf"}, 32'(overflow_cnt), 32'h0);
        check({tag, " rd_data"}, 32'(rd_data), 32'h0);
    endtask

    initial begin
        vecs = 0;
        errs = 0;
        rv[0]  = '{9'd0,   16'h0000};
        rv[1]  = '{9'd1,   16'h0001};
        rv[2]  = '{9'd5,   16'h0005};
        rv[3]  = '{9'd255, 16'h00FF};
        rv[4]  = '{9'd256, 16'h0100};
        rv[5]  = '{9'd511, 16'h01FF};
        rv[6]  = '{9'd0,   16'h7000};
        rv[7]  = '{9'd1,   16'h7001};
        rv[8]  = '{9'd199, 16'h70C7};
        rv[9]  = '{9'd200, 16'h70C8};
        rv[10] = '{9'd300, 16'h712C};
        rv[11] = '{9'd511, 16'h71FF};

        Reset       = 1'b1;
        in_valid    = 1'b0;
        in_data     = '0;
        rd_addr     = '0;
        tx_complete = 1'b1;
        tick();
        tick();
        chk_reset("por");
        Reset = 1'b0;

        fill(1, 16'h0000);
        check("first_wr state", 32'(bank_state), 32'h1);
        check("first_wr empty", 32'(rd_empty), 32'h1);
        fill(511, 16'h0001);
        check("b0 full state", 32'(bank_state), 32'h2);
        check("b0 full empty", 32'(rd_empty), 32'h0);
        rd_one("rd addr5", 9'd5, 16'h0005);
        rd_tab(0, 5);

        tx_complete = 1'b0;
        tick();
        check("b0 sending", 32'(bank_state), 32'h3);
        check("b0 sending empty", 32'(rd_empty), 32'h0);
        for (int i = 0; i < 512; i++) begin
            rd_addr = 9'(i);
            tick();
            if (rd_data !== 16'(i)) begin
                check("b0 sweep", 32'(rd_data), 32'(i));
            end else begin
                vecs++;
            end
        end
        tx_complete = 1'b1;
        tick();
        check("b0 released", 32'(bank_state), 32'h0);
        check("b0 released empty", 32'(rd_empty), 32'h1);

        fill(512, 16'h1000);
        check("b1 full", 32'(bank_state), 32'h8);
        check("b1 full empty", 32'(rd_empty), 32'h0);
        fill(512, 16'h2000);
        fill(3, 16'hDEAD);
        check("both full", 32'(bank_state), 32'hA);
        check("ovf3", 32'(overflow_cnt), 32'h3);
        rd_one("b1 w0", 9'd0, 16'h1000);
        rd_one("b1 w511", 9'd511, 16'h11FF);

        tx_complete = 1'b0;
        tick();
        check("b1 sending", 32'(bank_state), 32'hE);
        tx_complete = 1'b1;
        tick();
        check("b1 released", 32'(bank_state), 32'h2);
        check("rd b0 empty", 32'(rd_empty), 32'h0);
        rd_one("b0 w0 kept", 9'd0, 16'h2000);
        rd_one("b0 w511 kept", 9'd511, 16'h21FF);

        fill(511, 16'h3000);
        tx_complete = 1'b0;
        tick();
        check("pre-coincide", 32'(bank_state), 32'h7);
        in_valid    = 1'b1;
        in_data     = 16'h31FF;
        tx_complete = 1'b1;
        tick();
        in_valid = 1'b0;
        check("coincide state", 32'(bank_state), 32'h8);
        check("coincide empty", 32'(rd_empty), 32'h0);
        check("coincide ovf", 32'(overflow_cnt), 32'h3);
        fill(1, 16'h4000);
        check("resume b0", 32'(bank_state), 32'h9);
        check("resume ovf", 32'(overflow_cnt), 32'h3);
        rd_one("b1 last", 9'd511, 16'h31FF);
        tx_complete = 1'b0;
        tick();
        check("b1 send2", 32'(bank_state), 32'hD);
        tx_complete = 1'b1;
        tick();
        check("b1 free2", 32'(bank_state), 32'h1);
        check("filling empty", 32'(rd_empty), 32'h1);
        rd_one("b0 resume w0", 9'd0, 16'h4000);

        fill(511, 16'h4001);
        fill(512, 16'h5000);
        check("both full2", 32'(bank_state), 32'hA);
        fill(252, 16'hBEEF);
        check("ovf at max", 32'(overflow_cnt), 32'hFF);
        fill(8, 16'hBEEF);
        check("ovf saturated", 32'(overflow_cnt), 32'hFF);

        tx_complete = 1'b0;
        tick();
        check("pre-reset send", 32'(bank_state), 32'hB);
        Reset       = 1'b1;
        tx_complete = 1'b1;
        tick();
        chk_reset("rst_send");
        Reset = 1'b0;

        fill(200, 16'h6000);
        check("mid fill", 32'(bank_state), 32'h1);
        Reset = 1'b1;
        tick();
        chk_reset("rst_fill");
        Reset = 1'b0;

        fill(512, 16'h7000);
        check("refill state", 32'(bank_state), 32'h2);
        check("refill empty", 32'(rd_empty), 32'h0);
        rd_tab(6, 11);
        check("refill ovf", 32'(overflow_cnt), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule

// File: doc/iq_frame_buffer.md
Name: iq_frame_buffer

Overview:
Ping-pong frame buffer between the IQ demodulator output and the Ethernet frame transmitter. It collects 16-bit demodulated words into two banks of 512 words each. When a bank is full it is presented to the transmitter as one frame payload, through a word address port, a registered data port and an empty flag. The bank is released when the transmitter reports that the frame is complete.

Parameters:
ADDR_W, 9, log2 of words per bank (bank depth = 2^ADDR_W = 512)
DATA_W, 16, word width
OVF_W, 16, width of the saturating overflow counter

Ports:
Clk  in  1  system clock; all logic on posedge
Reset  in  1  synchronous, active-high
in_valid  in  1  in_data is valid this cycle; there is no backpressure
in_data  in  DATA_W  demodulated IQ word
rd_addr  in  ADDR_W  word address inside the current read bank, driven by the transmitter
rd_data  out  DATA_W  word at {rd_bank, rd_addr}, registered
rd_empty  out  1  low while the current read bank is READY or SENDING
tx_complete  in  1  transmitter idle flag: high = idle, low = sending a frame
overflow_cnt  out  OVF_W  number of words dropped, saturating
bank_state  out  4  {state of bank1, state of bank0}, 2 bits per bank

Behaviour:
- Storage: 2*2^ADDR_W x DATA_W simple dual-port RAM, one write port and one read port.
- Per-bank state, 2 bits each: FREE=0, FILLING=1, READY=2, SENDING=3.
- Write side:
  - Holds wr_bank (1 bit) and wr_cnt (ADDR_W bits).
  - On in_valid while bank[wr_bank] is FREE or FILLING: write in_data to {wr_bank, wr_cnt}, set the bank to FILLING, increment wr_cnt.
  - On the write with wr_cnt = 2^ADDR_W-1: set the bank to READY, wr_cnt wraps to 0, wr_bank toggles.
  - On in_valid while bank[wr_bank] is READY or SENDING (both banks busy): drop the word and increment overflow_cnt. overflow_cnt saturates at all-ones and never wraps.
  - Filling resumes at word 0 on the first in_valid after that bank becomes FREE.
- Read side:
  - Holds rd_bank (1 bit).
  - rd_empty = ~(bank[rd_bank]==READY | bank[rd_bank]==SENDING); combinational from registered state.
  - tx_complete is registered once (tc_q) for edge detection.
  - Falling edge (tc_q=1, tx_complete=0) while bank[rd_bank]==READY: bank becomes SENDING.
  - Rising edge (tc_q=0, tx_complete=1) while bank[rd_bank]==SENDING: bank becomes FREE and rd_bank toggles.
  - Edges seen in any other bank state are ignored.
- rd_data: registered RAM read of {rd_bank, rd_addr}. Latency is 1 cycle from rd_addr, and the read is independent of bank state.
- Simultaneous events:
  - If the last word of bank X is written in the same cycle that bank ~X is released to FREE, the writer continues into bank ~X with no dropped word.
  - A write and a read to the same address in the same cycle cannot occur, because a bank is never FILLING and READY/SENDING at once.
  - When a bank goes READY and the read pointer is on it, rd_empty falls in the following cycle.
- Reset, valid at any time including mid-frame:
  - Both banks FREE, wr_bank=rd_bank=0, wr_cnt=0, tc_q=1.
  - overflow_cnt=0, rd_data=0, rd_empty=1, bank_state=0.
  - RAM contents are not cleared.
- A partial bank is never presented: a frame always carries 2^ADDR_W words (1024 bytes).

Test Plan:
- Reset, then 512 in_valid words 0x0000..0x01FF -> bank_state=4'b0010, rd_empty=0 one cycle after the last write; rd_addr=5 gives rd_data=0x0005 one cycle later.
- Drive tx_complete 1->0, then read addresses 0..511, then tx_complete 0->1 -> bank0 goes SENDING then FREE, rd_bank=1, rd_empty=1 while bank1 is not full.
- Write 1024 words with tx_complete held high, then 3 more -> bank_state=4'b1010, overflow_cnt=3, no RAM write occurs.
- Release bank0 in the same cycle as the 512th write into bank1 -> the next in_valid writes {bank0, addr 0} and overflow_cnt is unchanged.
- Preload overflow_cnt near 0xFFFF, then keep both banks full -> overflow_cnt stays 0xFFFF.
- Assert Reset mid-fill at wr_cnt=200 and mid-SENDING -> all outputs return to reset values; the next 512 words fill bank0 from address 0.
